// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package shift_pkg;

    typedef enum logic {
        DIR_LSB_FIRST = 1'b0,
        DIR_MSB_FIRST = 1'b1
    } shift_dir_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    // Bit-count register width for a word of w bits (w >= 2).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 32'd1) ? int'($clog2(w)) : 32'd1;
    endfunction

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial input and valid/ready word output of the deserializer.
interface shift_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             ser_in;
    logic             ser_valid;
    logic             msb_first;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output ser_in, ser_valid, msb_first, flush, out_ready,
        input  out_data, out_valid, busy, overrun
    );

    modport slave (
        input  ser_in, ser_valid, msb_first, flush, out_ready,
        output out_data, out_valid, busy, overrun
    );
endinterface

// File: rtl/shift_out_hold.sv
// One-entry valid/ready holding register; flags completed words that find it full.
module shift_out_hold #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);

    logic drain;

    assign drain = valid & ready;

    // A same-edge drain frees the slot, so a completing word is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (!valid || drain) begin
                    data  <= word;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH qualified bits MSB- or LSB-first
// and hands each word to a one-entry output holding register.
module shift_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    shift_deserializer_if.slave bus
);
    import shift_pkg::*;

    localparam int unsigned CW = cnt_width(WIDTH);

    shift_state_e     state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n, shifted;
    shift_dir_e       dir, dir_n, cur_dir;
    logic             word_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sr    <= '0;
            dir   <= DIR_MSB_FIRST;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            dir   <= dir_n;
        end
    end

    // Direction is sampled only on the first bit of a word.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        dir_n     = dir;
        word_done = 1'b0;
        cur_dir   = (state == ST_IDLE) ? shift_dir_e'(bus.msb_first) : dir;
        shifted   = (cur_dir == DIR_MSB_FIRST) ? {sr[WIDTH-2:0], bus.ser_in}
                                               : {bus.ser_in, sr[WIDTH-1:1]};
        if (bus.flush) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            sr_n    = '0;
        end else if (bus.ser_valid) begin
            dir_n = cur_dir;
            if (cnt == CW'(WIDTH - 1)) begin
                word_done = 1'b1;
                state_n   = ST_IDLE;
                cnt_n     = '0;
                sr_n      = '0;
            end else begin
                state_n = ST_SHIFT;
                cnt_n   = CW'(cnt + 1'b1);
                sr_n    = shifted;
            end
        end
    end

    assign bus.busy = (state == ST_SHIFT);

    shift_out_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (word_done),
        .word    (shifted),
        .ready   (bus.out_ready),
        .data    (bus.out_data),
        .valid   (bus.out_valid),
        .overrun (bus.overrun)
    );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer with a word scoreboard checked on each handshake.
module tb_shift_deserializer;

    localparam int unsigned WIDTH = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    shift_deserializer_if #(.WIDTH(WIDTH)) bus ();

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total     = 0;
    int passed    = 0;
    int fail_cnt  = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected word from a bit sequence whose MSB is the first bit sent.
    function automatic logic [WIDTH-1:0] model_word(input logic [WIDTH-1:0] seq, input logic msb);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) r[i] = seq[WIDTH-1-i];
        return msb ? seq : r;
    endfunction

    // Handshake monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_word", 32'(bus.out_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic v, input logic msb, input logic fl);
        bus.ser_in    = b;
        bus.ser_valid = v;
        bus.msb_first = msb;
        bus.flush     = fl;
        step();
        bus.ser_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] seq, input logic msb, input logic push);
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (i == 0 && push) exp_q.push_back(model_word(seq, msb));
            drive_bit(seq[i], 1'b1, msb, 1'b0);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.ser_in    = 1'b0;
        bus.ser_valid = 1'b0;
        bus.msb_first = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_overrun",   32'(bus.overrun),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // MSB-first word 1,0,1,1 with busy tracking
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) exp_q.push_back(4'b1011);
            drive_bit(logic'(4'b1011 >> i), 1'b1, 1'b1, 1'b0);
            if (i != 0) check("msb_busy", 32'(bus.busy), 32'd1);
        end
        check("msb_busy_end",  32'(bus.busy),      32'd0);
        check("msb_valid",     32'(bus.out_valid), 32'd1);
        check("msb_data",      32'(bus.out_data),  32'hB);
        step();
        check("msb_valid_drop", 32'(bus.out_valid), 32'd0);

        // LSB-first word, same bits
        send_word(4'b1011, 1'b0, 1'b1);
        check("lsb_data", 32'(bus.out_data), 32'hD);
        step();

        // Direction toggles mid-word and ser_valid has gaps
        exp_q.push_back(4'b0110);
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        check("gap_busy", 32'(bus.busy), 32'd1);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        check("gap_data", 32'(bus.out_data), 32'h6);
        step();

        // Backpressure: second word is dropped with an overrun pulse
        bus.out_ready = 1'b0;
        send_word(4'h5, 1'b1, 1'b1);
        for (int i = 3; i >= 1; i--) begin
            drive_bit(logic'(4'hA >> i), 1'b1, 1'b1, 1'b0);
            check("bp_no_overrun", 32'(bus.overrun), 32'd0);
        end
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
        check("bp_overrun",   32'(bus.overrun),   32'd1);
        check("bp_hold_data", 32'(bus.out_data),  32'h5);
        check("bp_hold_vld",  32'(bus.out_valid), 32'd1);
        step();
        check("bp_overrun_pulse", 32'(bus.overrun),  32'd0);
        check("bp_data_stable",   32'(bus.out_data), 32'h5);
        bus.out_ready = 1'b1;
        step();
        check("bp_drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Completion on the same edge as a drain is a legal hand-over
        send_word(4'h3, 1'b1, 1'b1);
        for (int i = 3; i >= 1; i--) drive_bit(logic'(4'hC >> i), 1'b1, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        exp_q.push_back(4'hC);
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
        check("ho_overrun", 32'(bus.overrun),   32'd0);
        check("ho_valid",   32'(bus.out_valid), 32'd1);
        check("ho_data",    32'(bus.out_data),  32'hC);
        step();

        // Flush discards the partial word and its own bit
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        check("fl_busy_pre", 32'(bus.busy), 32'd1);
        drive_bit(1'b1, 1'b1, 1'b1, 1'b1);
        check("fl_busy_post", 32'(bus.busy),      32'd0);
        check("fl_no_valid",  32'(bus.out_valid), 32'd0);
        send_word(4'b1001, 1'b1, 1'b1);
        check("fl_data", 32'(bus.out_data), 32'h9);
        step();

        // Asynchronous reset with a held word and a partial word
        bus.out_ready = 1'b0;
        send_word(4'b1110, 1'b0, 1'b0);
        check("rs_held", 32'(bus.out_data), 32'h7);
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
        check("rs_busy_pre", 32'(bus.busy), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rs_valid", 32'(bus.out_valid), 32'd0);
        check("rs_busy",  32'(bus.busy),      32'd0);
        check("rs_data",  32'(bus.out_data),  32'd0);
        @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        step();
        send_word(4'b1101, 1'b1, 1'b1);
        check("rs_after_data", 32'(bus.out_data), 32'hD);
        step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver that sits at the far end of the bidirectional shift register's serial output. It collects one bit per qualified clock into a WIDTH-bit word, in MSB-first or LSB-first order. It presents each completed word on a valid/ready output with a one-word holding register, and flags words lost to backpressure.

## Interface
- WIDTH, 4: word width in bits; legal values are 2 and above.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is sampled on this edge.
- msb_first  input  1  1 means the first bit received lands in bit WIDTH-1; 0 means it lands in bit 0. Latched only at word start.
- flush  input  1  synchronous abort of the partial word.
- out_data  output  WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts the word when out_valid & out_ready.
- busy  output  1  a partial word is in progress (bit count ≠ 0).
- overrun  output  1  single-cycle pulse: a completed word was dropped.

## Operation
- Internal state:
  - sr[WIDTH-1:0], the shift register.
  - cnt, holding 0..WIDTH-1, width $clog2(WIDTH).
  - dir, the latched direction.
  - The holding register drives out_data and out_valid.
- Reset values:
  - sr=0, cnt=0, dir=1.
  - out_data=0, out_valid=0, busy=0, overrun=0.
- FSM: IDLE (cnt==0) and SHIFT (cnt>0). busy = (state==SHIFT).
- Behaviour on an edge with ser_valid=1 and flush=0:
  - IDLE: dir ← msb_first, and the bit is shifted using the new dir.
  - MSB-first shift: sr ← {sr[WIDTH-2:0], ser_in}.
  - LSB-first shift: sr ← {ser_in, sr[WIDTH-1:1]}.
  - If cnt < WIDTH-1: cnt ← cnt+1.
  - If cnt == WIDTH-1: the word is complete. The word is the post-shift sr value. cnt wraps to 0, sr ← 0, and the FSM returns to IDLE.
- ser_valid=0: no state change; gaps of any length are legal between bits.
- msb_first changes while in SHIFT are ignored.
- flush=1: cnt←0 and sr←0, overriding ser_valid; that cycle's bit is discarded. The holding register is unaffected.
- Holding register on word completion:
  - Loads if empty, or if it is being drained on the same edge (out_valid & out_ready). Then out_valid stays or becomes 1.
  - Otherwise the new word is dropped, out_data keeps the old word, and overrun pulses for one cycle.
- Drain without completion: out_valid & out_ready clears out_valid. out_data holds its last value.
- out_data and out_valid change only on clk edges or reset; they must be stable while out_valid=1 and out_ready=0.

## Timing
- Latency: out_valid rises on the same edge that samples the last bit, so it is visible in the cycle after that bit is presented.
- Throughput: one word per WIDTH qualified bits. Back-to-back words with out_ready=1 produce no bubble and no overrun.
- overrun is registered, high for exactly one cycle, aligned with the dropping edge.
- The completing bit and a drain on the same edge count as a legal hand-over, not an overrun.
- Asynchronous reset mid-word or mid-handshake: all state clears immediately on reset_n falling. The partial word and the held word are lost. Operation resumes on the first edge after reset_n rises.

## Structure
- Package shift_pkg holds:
  - the shift_dir_e enum: DIR_LSB_FIRST=0, DIR_MSB_FIRST=1.
  - a count-width helper, shared with the shift register.
- Natural sub-module: shift_out_hold, the one-entry valid/ready holding register with overrun detection. The shift/count FSM lives in the top.

## Test plan
All scenarios use WIDTH=4.
- **MSB-first word.** Stimulus: msb_first=1, out_ready=1, bits 1,0,1,1 on consecutive edges. Response: out_data=4'b1011, out_valid high for one cycle after the 4th edge, busy high for 3 cycles.
- **LSB-first word.** Stimulus: msb_first=0, same bits. Response: out_data=4'b1101.
- **Direction change mid-word and gaps.** Stimulus: msb_first toggles after bit 1, ser_valid has gaps, bits 0,1,1,0 with msb_first=1 at word start. Response: out_data=4'b0110.
- **Backpressure.** Stimulus: out_ready=0, send word 4'h5 then word 4'hA. Response: overrun pulses on the 8th bit, out_data stays 4'h5. Then raise out_ready for one cycle: 4'h5 is consumed and out_valid drops. Second part: completing a word on the same edge as a drain gives overrun=0 and the new word is presented.
- **Flush.** Stimulus: 2 bits, then flush with ser_valid=1, then bits 1,0,0,1 MSB-first. Response: the flush-cycle bit is ignored, busy=0 after the flush, out_data=4'b1001.
- **Reset mid-operation.** Stimulus: pull reset_n low between edges after 2 bits with a word held. Response: out_valid, busy and out_data go to 0 immediately. A following full word decodes correctly.
